// File: rtl/load_store_unit.sv
// Load/store unit: turns one core load/store into a req/gnt/rvalid bus access
// with byte lanes, and returns extended load data plus an error flag.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] TMO = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_R,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [2:0]  funct3_q, funct3_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  cnt_inc;

  logic        legal;
  logic        aligned;
  logic        issue;
  logic [3:0]  be_lat;
  logic [31:0] wdata_rep;

  function automatic logic [3:0] lane_mask(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001 << a;
      2'b01:   m = 4'b0011 << a;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] replicate(
    input logic [2:0]  f3,
    input logic [31:0] d
  );
    logic [31:0] r;
    case (f3[1:0])
      2'b00:   r = {4{d[7:0]}};
      2'b01:   r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] load_ext(
    input logic [31:0] w,
    input logic [1:0]  a,
    input logic [2:0]  f3
  );
    logic [31:0] sh;
    logic [31:0] r;
    // byte offset *8; halves are aligned so this also gives 16*a[1]
    sh = w >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{sh[7]}}, sh[7:0]};
      3'b100:  r = {24'b0, sh[7:0]};
      3'b001:  r = {{16{sh[15]}}, sh[15:0]};
      3'b101:  r = {16'b0, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  always_comb begin
    legal = 1'b0;
    case (req_funct3)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = !req_write;
      default:                legal = 1'b0;
    endcase
  end

  always_comb begin
    aligned = 1'b1;
    unique case (1'b1)
      (req_funct3[1:0] == 2'b01): aligned = !req_addr[0];
      (req_funct3[1:0] == 2'b10): aligned = (req_addr[1:0] == 2'b00);
      default:                    aligned = 1'b1;
    endcase
  end

  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    funct3_d = funct3_q;
    write_d  = write_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          funct3_d = req_funct3;
          write_d  = req_write;
          rdata_d  = 32'b0;
          err_d    = 1'b0;
          if (!(legal && aligned)) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (mem_gnt) begin
          cnt_d   = 8'd0;
          state_d = WAIT_R;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_inc;
        // a late rvalid on the timeout cycle still completes normally
        if (mem_rvalid) begin
          rdata_d = write_q ? 32'b0
                  : load_ext(mem_rdata, addr_q[1:0], funct3_q);
          state_d = RESP;
        end else if (cnt_inc == TMO) begin
          err_d   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= 32'b0;
      wdata_q  <= 32'b0;
      rdata_q  <= 32'b0;
      funct3_q <= 3'b0;
      write_q  <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      funct3_q <= funct3_d;
      write_q  <= write_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign issue     = (state_q == ISSUE);
  assign be_lat    = lane_mask(funct3_q, addr_q[1:0]);
  assign wdata_rep = replicate(funct3_q, wdata_q);

  assign req_ready  = reset && (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mem_req    = issue;
  assign mem_addr   = issue ? {addr_q[31:2], 2'b00} : 32'b0;
  assign mem_we     = issue && write_q;
  assign mem_be     = issue ? be_lat : 4'b0;
  assign mem_wdata  = (issue && write_q) ? wdata_rep : 32'b0;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'b0;
  assign resp_error = resp_valid && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: lanes, extension, errors,
// timeout and reset abort, with hand-computed expectations.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'b0;
  logic [31:0] req_wdata = 32'b0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        busy;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'b0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  load_store_unit #(
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_error (resp_error),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_gnt    (mem_gnt),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_wdata  (mem_wdata),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the unit idle. gnt is held low for gnt_hold
  // ISSUE cycles; rvalid comes on WAIT_R cycle rv_hold+1 (never if < 0).
  task automatic access(
    input string       tag,
    input logic        wr,
    input logic [2:0]  f3,
    input logic [31:0] a,
    input logic [31:0] wd,
    input logic [31:0] rd,
    input int          gnt_hold,
    input int          rv_hold,
    input logic [31:0] exp_addr,
    input logic [3:0]  exp_be,
    input logic [31:0] exp_wdata,
    input logic        exp_mem,
    input logic        exp_err,
    input logic [31:0] exp_rdata,
    input int          exp_lat
  );
    int  t;
    int  n_iss;
    int  n_wait;
    bit  seen_req;
    n_iss = 0;
    n_wait = 0;
    seen_req = 0;
    check({tag, ".ready"}, 32'(req_ready), 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    mem_rdata  = rd;
    @(negedge clk);
    req_valid = 1'b0;
    for (t = 1; t < 300; t++) begin
      if (resp_valid) break;
      if (mem_req) begin
        if (n_iss == 0) begin
          check({tag, ".addr"}, mem_addr, exp_addr);
          check({tag, ".we"}, 32'(mem_we), 32'(wr));
          check({tag, ".be"}, 32'(mem_be), 32'(exp_be));
          check({tag, ".wdata"}, mem_wdata, exp_wdata);
        end else begin
          check({tag, ".addr_hold"}, mem_addr, exp_addr);
          check({tag, ".be_hold"}, 32'(mem_be), 32'(exp_be));
          check({tag, ".wdata_hold"}, mem_wdata, exp_wdata);
          check({tag, ".busy"}, 32'(busy), 32'd1);
        end
        seen_req = 1;
        n_iss++;
        mem_gnt = (n_iss > gnt_hold);
        mem_rvalid = 1'b0;
      end else if (seen_req) begin
        n_wait++;
        mem_gnt = 1'b0;
        mem_rvalid = (rv_hold >= 0) && (n_wait > rv_hold);
      end else begin
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
      end
      @(negedge clk);
    end
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    check({tag, ".lat"}, 32'(t), 32'(exp_lat));
    check({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
    check({tag, ".err"}, 32'(resp_error), 32'(exp_err));
    check({tag, ".rdata"}, resp_rdata, exp_rdata);
    check({tag, ".mem_used"}, 32'(seen_req), 32'(exp_mem));
    @(negedge clk);
    check({tag, ".pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset state, with a stale rvalid present
    mem_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.mem_req", 32'(mem_req), 32'd0);
    check("rst.resp_valid", 32'(resp_valid), 32'd0);
    check("rst.mem_be", 32'(mem_be), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("stale.resp_valid", 32'(resp_valid), 32'd0);
    check("stale.busy", 32'(busy), 32'd0);

    // loads: lanes and extension
    access("lb", 1'b0, 3'b000, 32'h102, 32'h0, 32'h8899AABB, 0, 0,
           32'h100, 4'b0100, 32'h0, 1'b1, 1'b0, 32'hFFFFFF99, 3);
    access("lhu", 1'b0, 3'b101, 32'h102, 32'h0, 32'h8899AABB, 0, 0,
           32'h100, 4'b1100, 32'h0, 1'b1, 1'b0, 32'h00008899, 3);
    access("lh", 1'b0, 3'b001, 32'h100, 32'h0, 32'h8899AABB, 0, 0,
           32'h100, 4'b0011, 32'h0, 1'b1, 1'b0, 32'hFFFFAABB, 3);
    access("lbu", 1'b0, 3'b100, 32'h103, 32'h0, 32'h8899AABB, 0, 0,
           32'h100, 4'b1000, 32'h0, 1'b1, 1'b0, 32'h00000088, 3);
    access("lb0", 1'b0, 3'b000, 32'h200, 32'h0, 32'h8899AA3B, 0, 0,
           32'h200, 4'b0001, 32'h0, 1'b1, 1'b0, 32'h0000003B, 3);
    access("lw", 1'b0, 3'b010, 32'h104, 32'h0, 32'h8899AABB, 0, 1,
           32'h104, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h8899AABB, 4);

    // stores: replication, gnt stall
    access("sb", 1'b1, 3'b000, 32'h203, 32'h12345678, 32'hDEADBEEF, 3, 0,
           32'h200, 4'b1000, 32'h78787878, 1'b1, 1'b0, 32'h0, 6);
    access("sh", 1'b1, 3'b001, 32'h202, 32'h12345678, 32'h0, 0, 0,
           32'h200, 4'b1100, 32'h56785678, 1'b1, 1'b0, 32'h0, 3);
    access("sw", 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 1, 0,
           32'h300, 4'b1111, 32'hCAFEF00D, 1'b1, 1'b0, 32'h0, 4);

    // errors: no bus traffic, response one cycle after accept
    access("lw_mis", 1'b0, 3'b010, 32'h106, 32'h0, 32'h0, 0, 0,
           32'h0, 4'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1);
    access("sh_mis", 1'b1, 3'b001, 32'h001, 32'h0, 32'h0, 0, 0,
           32'h0, 4'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1);
    access("ld_f3_011", 1'b0, 3'b011, 32'h100, 32'h0, 32'h0, 0, 0,
           32'h0, 4'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1);
    access("st_f3_100", 1'b1, 3'b100, 32'h100, 32'h0, 32'h0, 0, 0,
           32'h0, 4'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1);

    // timeout after 4 WAIT_R cycles; rvalid on the 4th wins
    access("tmo", 1'b0, 3'b010, 32'h100, 32'h0, 32'h11223344, 0, -1,
           32'h100, 4'b1111, 32'h0, 1'b1, 1'b1, 32'h0, 6);
    access("tmo_edge", 1'b0, 3'b010, 32'h100, 32'h0, 32'h11223344, 0, 3,
           32'h100, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h11223344, 6);
    access("st_tmo", 1'b1, 3'b010, 32'h100, 32'h55AA55AA, 32'h0, 0, -1,
           32'h100, 4'b1111, 32'h55AA55AA, 1'b1, 1'b1, 32'h0, 6);

    // reset during WAIT_R
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h100;
    mem_gnt    = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("abort.issue", 32'(mem_req), 32'd1);
    @(negedge clk);
    mem_gnt = 1'b0;
    check("abort.wait_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.ready", 32'(req_ready), 32'd0);
    check("abort.mem_req", 32'(mem_req), 32'd0);
    check("abort.resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b1;
    @(negedge clk);
    mem_rvalid = 1'b0;
    check("abort.stale_resp", 32'(resp_valid), 32'd0);
    check("abort.stale_busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("abort.quiet", 32'(resp_valid), 32'd0);
    access("post_rst", 1'b0, 3'b010, 32'h100, 32'h0, 32'h01234567, 0, 0,
           32'h100, 4'b1111, 32'h0, 1'b1, 1'b0, 32'h01234567, 3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Multi-cycle data-memory access unit directly downstream of the RV32I core's execute stage. It replaces the core's direct word-only data memory port.
- Accepts one load/store request per transaction: ALU-computed address, rs2 data, funct3.
- Drives a req/gnt/rvalid data-memory bus with byte lanes, and returns sign- or zero-extended load data plus an error flag.
- The core stalls on `busy`.

Parameters:
TIMEOUT_CYCLES, 255, WAIT_R cycles without mem_rvalid before an error response (legal 1..255)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
req_valid  input  1  core presents a request
req_ready  output  1  unit accepts a request this cycle
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
req_addr  input  32  byte address
req_wdata  input  32  store data (rs2)
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_error  output  1  qualifies resp_valid: misaligned, illegal funct3, or timeout
busy  output  1  state != IDLE
mem_req  output  1  bus request
mem_gnt  input  1  bus accepts request
mem_addr  output  32  {addr[31:2],2'b00}
mem_we  output  1  write strobe
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_rvalid  input  1  read data valid / write acknowledge
mem_rdata  input  32  read word

Behaviour:
- Reset values: state IDLE; all outputs 0, including req_ready, which is (state==IDLE) gated by reset high. Timeout counter 0. Latched request fields 0.
- State machine: IDLE, ISSUE, WAIT_R, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch addr, wdata, funct3 and write.
  - Check legality and alignment:
    - Half requires addr[0]=0; word requires addr[1:0]=0.
    - Loads: funct3 011/110/111 illegal.
    - Stores: funct3 other than 000/001/010 illegal.
  - Illegal or misaligned: go to RESP with error set; no mem_req is ever issued.
  - Otherwise go to ISSUE.
- ISSUE:
  - mem_req=1; mem_addr/we/be/wdata come from registers and stay stable until mem_gnt.
  - mem_gnt=1: go to WAIT_R, clear the counter.
- WAIT_R:
  - mem_req=0; counter increments each cycle.
  - mem_rvalid: capture result, go to RESP.
  - Counter reaching TIMEOUT_CYCLES without rvalid: go to RESP with error.
  - rvalid in the same cycle as the timeout: rvalid wins, no error.
- RESP:
  - resp_valid=1 for exactly one cycle; resp_rdata/resp_error are held registered values.
  - Next state is IDLE. Back-to-back requests therefore leave at least one idle cycle (req_ready=1 only in IDLE).
- Byte enables: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111. Loads use the same mask with mem_we=0.
- Store data replication: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- Load extraction:
  - Byte: rdata[8*addr[1:0] +: 8].
  - Half: rdata[16*addr[1] +: 16].
  - Sign-extend when funct3[2]=0, zero-extend when funct3[2]=1.
- Stores complete on mem_rvalid (write ack); resp_rdata=0.
- Ignored inputs:
  - mem_gnt outside ISSUE.
  - mem_rvalid outside WAIT_R, including a stale rvalid after reset.
  - req_valid outside IDLE.
- Latency:
  - Best-case aligned access: accept at cycle 0, mem_req at 1 (gnt at 1), rvalid at 2, resp_valid at 3.
  - Error response: resp_valid at cycle 1.
- Reset asserted mid-transaction: immediately return to IDLE, all outputs 0, in-flight result discarded.

Test Plan:
1. LB addr 0x102, mem_rdata 0x8899AABB, gnt and rvalid immediate -> mem_addr 0x100, mem_be 0100, resp_rdata 0xFFFFFF99, resp_valid 3 cycles after accept, error 0.
2. LHU addr 0x102, same rdata -> mem_be 1100, resp_rdata 0x00008899; LH addr 0x100 -> 0xFFFFAABB.
3. SB addr 0x203, wdata 0x12345678 -> mem_addr 0x200, mem_we 1, mem_be 1000, mem_wdata 0x78787878. Hold gnt low 3 cycles: mem_* stable and busy=1 throughout; after rvalid, resp_rdata 0.
4. LW addr 0x106; then SH addr 0x001; then load funct3 011 -> each gives resp_error=1, resp_valid one cycle after accept, mem_req never asserted.
5. TIMEOUT_CYCLES=4, gnt given, rvalid withheld -> resp_valid with resp_error=1 after 4 WAIT_R cycles. Repeat with rvalid on the 4th cycle -> error 0, data returned.
6. reset low during WAIT_R -> outputs 0 same cycle. reset high, then rvalid pulse -> ignored, no resp_valid. Next LW 0x100 completes normally.
